// File: rtl/fifteen_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fifteen_pkg
// Brief    : Shared types, state codes and the eight 15-sum lines for Fifteen.
// Revision : 1.0
// ----------------------------------------------------------------------------
package fifteen_pkg;

  typedef logic [3:0] move_t;
  typedef logic [8:0] set_t;    // bit n-1 represents number n
  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_NEWG   = 3'd1;
  localparam logic [2:0] ST_WAIT_C = 3'd2;
  localparam logic [2:0] ST_THINK  = 3'd3;
  localparam logic [2:0] ST_SETUP  = 3'd4;
  localparam logic [2:0] ST_PRESS  = 3'd5;
  localparam logic [2:0] ST_REL    = 3'd6;
  localparam logic [2:0] ST_DONE   = 3'd7;

  // {2,7,6} {9,5,1} {4,3,8} {2,9,4} {7,5,3} {6,1,8} {2,5,8} {4,5,6}
  localparam set_t [0:7] TRIPLES = {9'h062, 9'h111, 9'h08C, 9'h10A,
                                    9'h054, 9'h0A1, 9'h092, 9'h038};

  function automatic set_t move_bit(input move_t m);
    set_t r;
    r = '0;
    if (m >= 4'd1 && m <= 4'd9) r = set_t'(1) << (m - 4'd1);
    return r;
  endfunction

  function automatic logic has_triple(input set_t s);
    logic r;
    r = 1'b0;
    for (int t = 0; t < 8; t++) begin
      if ((TRIPLES[t] & s) == TRIPLES[t]) r = 1'b1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifteen_move_picker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fifteen_move_picker
// Brief    : Combinational move choice: win, else block, else lowest free.
// Revision : 1.0
// ----------------------------------------------------------------------------
module fifteen_move_picker
  import fifteen_pkg::*;
(
  input  set_t  i_h_set,
  input  set_t  i_c_set,
  output move_t o_move
);

  set_t w_occ;
  set_t w_win;
  set_t w_blk;
  set_t w_cand;

  always_comb begin
    w_occ  = i_h_set | i_c_set;
    w_win  = '0;
    w_blk  = '0;
    w_cand = '0;
    o_move = '0;
    // A free number completes a line when it is the only member the owner lacks.
    for (int n = 0; n < 9; n++) begin
      for (int t = 0; t < 8; t++) begin
        if (!w_occ[n] && TRIPLES[t][n]) begin
          if ((TRIPLES[t] & ~i_h_set) == (set_t'(1) << n)) w_win[n] = 1'b1;
          if ((TRIPLES[t] & ~i_c_set) == (set_t'(1) << n)) w_blk[n] = 1'b1;
        end
      end
    end
    if (|w_win)      w_cand = w_win;
    else if (|w_blk) w_cand = w_blk;
    else             w_cand = ~w_occ;
    for (int n = 8; n >= 0; n--) begin
      if (w_cand[n]) o_move = move_t'(n + 1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifteen_auto_player.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fifteen_auto_player
// Brief    : Automatic human-side opponent driving hMove/enter_L/newGame_L.
//            Optional AUTO_REPLAY_EN: restart a new game 16 cycles after DONE.
// Revision : 1.0
// ----------------------------------------------------------------------------
module fifteen_auto_player
  import fifteen_pkg::*;
#(
  parameter int SETUP_CYCLES   = 1,
  parameter int PRESS_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] cMove,
  input  logic       cWin,
  output logic [3:0] hMove,
  output logic       enter_L,
  output logic       newGame_L,
  output logic       hWin,
  output logic       busy,
  output logic       timeout,
  output logic       illegal
);

  localparam int C_CNT_MAX = TIMEOUT_CYCLES + SETUP_CYCLES + PRESS_CYCLES + 16;
  localparam int C_CW      = $clog2(C_CNT_MAX + 1);

  state_t          r_state, w_state_nxt;
  logic [C_CW-1:0] r_cnt, w_cnt_nxt;
  set_t            r_cset, w_cset_nxt;
  set_t            r_hset, w_hset_nxt;
  move_t           r_hmove, w_hmove_nxt;
  logic            r_hwin, w_hwin_nxt;
  logic            r_tout, w_tout_nxt;
  logic            r_ill, w_ill_nxt;
  logic            r_enter_l, r_newg_l, r_busy;
  move_t           w_pick;
  set_t            w_cbit;
  set_t            w_hset_rel;
  logic            w_new_move;

  fifteen_move_picker u_picker (
    .i_h_set (r_hset),
    .i_c_set (r_cset),
    .o_move  (w_pick)
  );

  assign w_cbit     = move_bit(cMove);
  assign w_new_move = (|w_cbit) && !(|(w_cbit & r_cset));
  assign w_hset_rel = r_hset | move_bit(r_hmove);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_cset_nxt  = r_cset;
    w_hset_nxt  = r_hset;
    w_hmove_nxt = r_hmove;
    w_hwin_nxt  = r_hwin;
    w_tout_nxt  = r_tout;
    w_ill_nxt   = r_ill;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_NEWG;
          w_cset_nxt  = '0;
          w_hset_nxt  = '0;
          w_hwin_nxt  = 1'b0;
          w_tout_nxt  = 1'b0;
          w_ill_nxt   = 1'b0;
        end
`ifdef AUTO_REPLAY_EN
        else if (r_state == ST_DONE) begin
          if (r_cnt == C_CW'(15)) begin
            w_state_nxt = ST_NEWG;
            w_cset_nxt  = '0;
            w_hset_nxt  = '0;
            w_hwin_nxt  = 1'b0;
            w_tout_nxt  = 1'b0;
            w_ill_nxt   = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + C_CW'(1);
          end
        end
`endif
      end
      ST_NEWG: w_state_nxt = ST_WAIT_C;
      ST_WAIT_C: begin
        // A fresh move takes precedence over an expiring timeout.
        if (w_new_move) begin
          if (|(w_cbit & r_hset)) begin
            w_ill_nxt   = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_cset_nxt = r_cset | w_cbit;
            if (cWin || (&(r_cset | w_cbit | r_hset))) w_state_nxt = ST_DONE;
            else                                       w_state_nxt = ST_THINK;
          end
        end else if (r_cnt == C_CW'(TIMEOUT_CYCLES - 1)) begin
          w_tout_nxt  = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + C_CW'(1);
        end
      end
      ST_THINK: begin
        w_hmove_nxt = w_pick;
        w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        if (r_cnt == C_CW'(SETUP_CYCLES - 1)) w_state_nxt = ST_PRESS;
        else                                  w_cnt_nxt   = r_cnt + C_CW'(1);
      end
      ST_PRESS: begin
        if (r_cnt == C_CW'(PRESS_CYCLES - 1)) w_state_nxt = ST_REL;
        else                                  w_cnt_nxt   = r_cnt + C_CW'(1);
      end
      ST_REL: begin
        w_hset_nxt = w_hset_rel;
        if (has_triple(w_hset_rel)) begin
          w_hwin_nxt  = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (&(w_hset_rel | r_cset)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_WAIT_C;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they leave glitch-free flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_cset    <= '0;
      r_hset    <= '0;
      r_hmove   <= '0;
      r_hwin    <= 1'b0;
      r_tout    <= 1'b0;
      r_ill     <= 1'b0;
      r_enter_l <= 1'b1;
      r_newg_l  <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cset    <= w_cset_nxt;
      r_hset    <= w_hset_nxt;
      r_hmove   <= w_hmove_nxt;
      r_hwin    <= w_hwin_nxt;
      r_tout    <= w_tout_nxt;
      r_ill     <= w_ill_nxt;
      r_enter_l <= (w_state_nxt != ST_PRESS);
      r_newg_l  <= (w_state_nxt != ST_NEWG);
      r_busy    <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
    end
  end

  assign hMove     = r_hmove;
  assign enter_L   = r_enter_l;
  assign newGame_L = r_newg_l;
  assign hWin      = r_hwin;
  assign busy      = r_busy;
  assign timeout   = r_tout;
  assign illegal   = r_ill;

endmodule
`default_nettype wire

// File: tb/tb_fifteen_auto_player.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_fifteen_auto_player
// Brief    : Self-checking bench; reference picks use the "three distinct
//            numbers summing to 15" rule. Revision : 1.0
// ----------------------------------------------------------------------------
module tb_fifteen_auto_player;

  localparam int PRESS = 2;
  localparam int SETUP = 1;
  localparam int TOUT  = 64;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] cMove = 4'd0;
  logic       cWin  = 1'b0;
  logic [3:0] hMove;
  logic       enter_L, newGame_L, hWin, busy, timeout, illegal;

  int checks   = 0;
  int failures = 0;
  int own [1:9];   // 0 free, 1 computer, 2 human

  fifteen_auto_player #(
    .SETUP_CYCLES   (SETUP),
    .PRESS_CYCLES   (PRESS),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .cMove     (cMove),
    .cWin      (cWin),
    .hMove     (hMove),
    .enter_L   (enter_L),
    .newGame_L (newGame_L),
    .hWin      (hWin),
    .busy      (busy),
    .timeout   (timeout),
    .illegal   (illegal)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit has_line(input int who);
    for (int a = 1; a <= 9; a++)
      for (int b = a + 1; b <= 9; b++)
        for (int c = b + 1; c <= 9; c++)
          if (a + b + c == 15 && own[a] == who && own[b] == who && own[c] == who) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit board_full();
    for (int n = 1; n <= 9; n++) if (own[n] == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int completes(input int n, input int who);
    for (int a = 1; a <= 9; a++)
      for (int b = a + 1; b <= 9; b++)
        if (a != n && b != n && a + b + n == 15 && own[a] == who && own[b] == who) return 1;
    return 0;
  endfunction

  function automatic int model_pick();
    for (int n = 1; n <= 9; n++) if (own[n] == 0 && completes(n, 2) != 0) return n;
    for (int n = 1; n <= 9; n++) if (own[n] == 0 && completes(n, 1) != 0) return n;
    for (int n = 1; n <= 9; n++) if (own[n] == 0) return n;
    return 0;
  endfunction

  task automatic start_game();
    for (int n = 1; n <= 9; n++) own[n] = 0;
    cMove = 4'd0;
    cWin  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("newg_low", newGame_L, 0);
    chk("newg_busy", busy, 1);
    chk("newg_flags_clr", {hWin, timeout, illegal}, 0);
    tick();
    chk("newg_release", newGame_L, 1);
  endtask

  task automatic comp_turn(input int m, output bit over);
    int   cyc;
    int   low;
    int   exp_p;
    logic [3:0] prev_h;
    logic prev_e;
    over = 1'b0;
    if (own[m] == 2) begin
      cMove = 4'(m);
      tick();
      chk("illegal_flag", illegal, 1);
      chk("illegal_busy", busy, 0);
      over = 1'b1;
      return;
    end
    own[m] = 1;
    cWin   = has_line(1);
    cMove  = 4'(m);
    if (has_line(1) || board_full()) begin
      tick();
      chk("cend_busy", busy, 0);
      chk("cend_hwin", hWin, 0);
      cWin = 1'b0;
      over = 1'b1;
      return;
    end
    exp_p  = model_pick();
    cyc    = 0;
    prev_h = hMove;
    prev_e = enter_L;
    while (enter_L !== 1'b0 && cyc < 20) begin
      prev_h = hMove;
      prev_e = enter_L;
      tick();
      cyc++;
    end
    chk("enter_fall_latency", cyc, 2 + SETUP);
    chk("setup_hmove", prev_h, exp_p);
    chk("setup_enter_high", prev_e, 1);
    chk("press_hmove", hMove, exp_p);
    low = 0;
    while (enter_L === 1'b0 && low < 20) begin
      low++;
      tick();
    end
    chk("press_len", low, PRESS);
    chk("rel_hmove", hMove, exp_p);
    chk("rel_busy", busy, 1);
    own[exp_p] = 2;
    tick();
    chk("after_rel_enter", enter_L, 1);
    if (has_line(2)) begin
      chk("hwin_flag", hWin, 1);
      chk("hwin_busy", busy, 0);
      over = 1'b1;
    end else if (board_full()) begin
      chk("full_busy", busy, 0);
      chk("full_hwin", hWin, 0);
      over = 1'b1;
    end else begin
      chk("cont_busy", busy, 1);
      chk("cont_hwin", hWin, 0);
    end
  endtask

  initial begin
    bit over;
    int cyc;
    int m;
    int cnt;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    chk("rst_hmove", hMove, 0);
    chk("rst_enter", enter_L, 1);
    chk("rst_newg", newGame_L, 1);
    chk("rst_flags", {hWin, busy, timeout, illegal}, 0);

    // Directed game: 5->1, 3->7 (block), 2->8 (block), 4->6 (win)
    start_game();
    comp_turn(5, over);
    chk("dir_h1", hMove, 1);
    start = 1'b1;            // ignored while busy
    tick();
    start = 1'b0;
    chk("busy_start_newg", newGame_L, 1);
    chk("busy_start_busy", busy, 1);
    comp_turn(3, over);
    chk("dir_h7", hMove, 7);
    comp_turn(2, over);
    chk("dir_h8", hMove, 8);
    comp_turn(4, over);
    chk("dir_h6", hMove, 6);
    chk("dir_over", over, 1);
    chk("dir_hwin", hWin, 1);

    // Timeout after a completed human move
    start_game();
    comp_turn(5, over);
    cyc = 0;
    while (timeout !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("timeout_cycles", cyc, TOUT);
    chk("timeout_busy", busy, 0);
    chk("timeout_enter", enter_L, 1);

    // Computer replays a human-claimed number
    start_game();
    comp_turn(5, over);
    comp_turn(1, over);
    chk("illegal_over", over, 1);

    // Reset during PRESS
    start_game();
    cMove = 4'd5;
    cyc = 0;
    while (enter_L !== 1'b0 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("pre_reset_press", enter_L, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_enter", enter_L, 1);
    chk("midrst_hmove", hMove, 0);
    chk("midrst_busy", busy, 0);

    // Randomized games against the reference model
    for (int g = 0; g < 12; g++) begin
      start_game();
      over = 1'b0;
      cnt  = 0;
      while (!over && cnt < 12) begin
        m = 0;
        if ($urandom_range(7) == 0) begin
          for (int n = 1; n <= 9; n++) if (own[n] == 2 && m == 0) m = n;
        end
        if (m == 0) begin
          do m = int'($urandom_range(9, 1)); while (own[m] != 0);
        end
        comp_turn(m, over);
        cnt++;
      end
      chk("rand_game_ended", over, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
